// File: rtl/div_unit_if.sv
// rtl/div_unit_if.sv - divide request/result bundle between the EX stage and div_unit
interface div_unit_if;
    logic        start_i;
    logic        signed_div_i;
    logic [31:0] opdata1_i;
    logic [31:0] opdata2_i;
    logic        annul_i;
    logic [63:0] result_o;
    logic        ready_o;

    modport master (
        output start_i, signed_div_i, opdata1_i, opdata2_i, annul_i,
        input  result_o, ready_o
    );

    modport slave (
        input  start_i, signed_div_i, opdata1_i, opdata2_i, annul_i,
        output result_o, ready_o
    );
endinterface

// File: rtl/div_unit.sv
// rtl/div_unit.sv - 32-cycle restoring DIV/DIVU unit; DIV_UNIT_ANNUL_EN enables annul_i cancel
module div_unit (
    input  logic       clk,
    input  logic       rst,
    div_unit_if.slave  bus
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_BYZERO = 2'd1,
        S_ON     = 2'd2,
        S_END    = 2'd3
    } state_e;

    state_e      state_q, state_d;
    logic [4:0]  cnt_q, cnt_d;
    logic [31:0] rem_q, rem_d;
    logic [31:0] quo_q, quo_d;
    logic [31:0] dvs_q, dvs_d;
    logic        neg_quo_q, neg_quo_d;
    logic        neg_rem_q, neg_rem_d;
    logic        ready_q, ready_d;
    logic [63:0] result_q, result_d;

    logic        annul_eff;
`ifdef DIV_UNIT_ANNUL_EN
    assign annul_eff = bus.annul_i;
`else
    logic annul_unused;
    assign annul_unused = bus.annul_i;
    assign annul_eff    = 1'b0;
`endif

    logic [31:0] mag1, mag2;
    logic [32:0] shift_w;
    logic [33:0] sub_w;
    logic        borrow_w;
    logic [31:0] rem_nxt, quo_nxt, rem_fix, quo_fix;

    assign mag1 = (bus.signed_div_i && bus.opdata1_i[31]) ? (~bus.opdata1_i + 32'd1) : bus.opdata1_i;
    assign mag2 = (bus.signed_div_i && bus.opdata2_i[31]) ? (~bus.opdata2_i + 32'd1) : bus.opdata2_i;

    // quo_q doubles as the dividend shift register: its MSB feeds the partial remainder
    assign shift_w  = {rem_q, quo_q[31]};
    assign sub_w    = {1'b0, shift_w} - {2'b00, dvs_q};
    assign borrow_w = sub_w[33];
    assign rem_nxt  = borrow_w ? shift_w[31:0] : sub_w[31:0];
    assign quo_nxt  = {quo_q[30:0], ~borrow_w};
    assign quo_fix  = neg_quo_q ? (~quo_nxt + 32'd1) : quo_nxt;
    assign rem_fix  = neg_rem_q ? (~rem_nxt + 32'd1) : rem_nxt;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        rem_d     = rem_q;
        quo_d     = quo_q;
        dvs_d     = dvs_q;
        neg_quo_d = neg_quo_q;
        neg_rem_d = neg_rem_q;
        ready_d   = ready_q;
        result_d  = result_q;

        if (annul_eff) begin
            state_d  = S_IDLE;
            ready_d  = 1'b0;
            result_d = 64'd0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    ready_d  = 1'b0;
                    result_d = 64'd0;
                    if (bus.start_i) begin
                        if (bus.opdata2_i == 32'd0) begin
                            state_d = S_BYZERO;
                        end else begin
                            state_d   = S_ON;
                            cnt_d     = 5'd0;
                            rem_d     = 32'd0;
                            quo_d     = mag1;
                            dvs_d     = mag2;
                            neg_quo_d = bus.signed_div_i && (bus.opdata1_i[31] ^ bus.opdata2_i[31]);
                            neg_rem_d = bus.signed_div_i && bus.opdata1_i[31];
                        end
                    end
                end
                S_BYZERO: begin
                    result_d = 64'd0;
                    if (!bus.start_i) begin
                        state_d = S_IDLE;
                        ready_d = 1'b0;
                    end else begin
                        state_d = S_END;
                        ready_d = 1'b1;
                    end
                end
                S_ON: begin
                    if (!bus.start_i) begin
                        state_d  = S_IDLE;
                        ready_d  = 1'b0;
                        result_d = 64'd0;
                    end else begin
                        rem_d = rem_nxt;
                        quo_d = quo_nxt;
                        cnt_d = cnt_q + 5'd1;
                        if (cnt_q == 5'd31) begin
                            state_d  = S_END;
                            ready_d  = 1'b1;
                            result_d = {rem_fix, quo_fix};
                        end
                    end
                end
                S_END: begin
                    if (!bus.start_i) begin
                        state_d  = S_IDLE;
                        ready_d  = 1'b0;
                        result_d = 64'd0;
                    end
                end
                default: begin
                    state_d  = S_IDLE;
                    ready_d  = 1'b0;
                    result_d = 64'd0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            cnt_q     <= 5'd0;
            rem_q     <= 32'd0;
            quo_q     <= 32'd0;
            dvs_q     <= 32'd0;
            neg_quo_q <= 1'b0;
            neg_rem_q <= 1'b0;
            ready_q   <= 1'b0;
            result_q  <= 64'd0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            rem_q     <= rem_d;
            quo_q     <= quo_d;
            dvs_q     <= dvs_d;
            neg_quo_q <= neg_quo_d;
            neg_rem_q <= neg_rem_d;
            ready_q   <= ready_d;
            result_q  <= result_d;
        end
    end

    assign bus.ready_o  = ready_q;
    assign bus.result_o = result_q;

endmodule

// File: tb/tb_div_unit.sv
// tb/tb_div_unit.sv - directed-vector bench for div_unit
module tb_div_unit;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_vec = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    div_unit_if bus ();

    div_unit dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    task automatic check_vec(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%016h, expected 0x%016h", tag, obs, exp);
        end
    endtask

    // Raises start with the operands, scrambles operands after sampling, waits for ready.
    task automatic do_div(input string tag, input logic sgn, input logic [31:0] a,
                          input logic [31:0] b, input logic [63:0] exp, input int exp_cyc);
        int cyc;
        logic got;
        @(negedge clk);
        bus.signed_div_i = sgn;
        bus.opdata1_i    = a;
        bus.opdata2_i    = b;
        bus.start_i      = 1'b1;
        cyc = 0;
        got = 1'b0;
        while (cyc < 60 && !got) begin
            @(posedge clk);
            @(negedge clk);
            cyc++;
            if (cyc == 1) begin
                bus.opdata1_i    = $urandom;
                bus.opdata2_i    = $urandom;
                bus.signed_div_i = ~sgn;
            end
            if (bus.ready_o) got = 1'b1;
        end
        check_vec({tag, "_latency"}, 64'(cyc), 64'(exp_cyc));
        check_vec({tag, "_result"}, bus.result_o, exp);
    endtask

    task automatic release_start(input string tag);
        @(negedge clk);
        bus.start_i = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check_vec({tag, "_rel_ready"}, 64'(bus.ready_o), 64'd0);
        check_vec({tag, "_rel_result"}, bus.result_o, 64'd0);
    endtask

    initial begin
        logic       seen;
        logic [63:0] held;
        int         cyc;

        bus.start_i      = 1'b0;
        bus.signed_div_i = 1'b0;
        bus.opdata1_i    = 32'd0;
        bus.opdata2_i    = 32'd0;
        bus.annul_i      = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_vec("reset_ready", 64'(bus.ready_o), 64'd0);
        check_vec("reset_result", bus.result_o, 64'd0);
        rst = 1'b0;

        do_div("divu_100_7", 1'b0, 32'd100, 32'd7, {32'h0000_0002, 32'h0000_000E}, 33);
        release_start("divu_100_7");

        do_div("div_m7_2", 1'b1, 32'hFFFF_FFF9, 32'd2, {32'hFFFF_FFFF, 32'hFFFF_FFFD}, 33);
        release_start("div_m7_2");

        do_div("divu_fff9_2", 1'b0, 32'hFFFF_FFF9, 32'd2, {32'h0000_0001, 32'h7FFF_FFFC}, 33);
        release_start("divu_fff9_2");

        do_div("div_7_m2", 1'b1, 32'd7, 32'hFFFF_FFFE, {32'h0000_0001, 32'hFFFF_FFFD}, 33);
        release_start("div_7_m2");

        do_div("div_m7_m2", 1'b1, 32'hFFFF_FFF9, 32'hFFFF_FFFE, {32'hFFFF_FFFF, 32'h0000_0003}, 33);
        release_start("div_m7_m2");

        do_div("div_by0", 1'b1, 32'd5, 32'd0, 64'd0, 2);
        check_vec("div_by0_ready", 64'(bus.ready_o), 64'd1);
        release_start("div_by0");

        do_div("div_ovf", 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, {32'h0000_0000, 32'h8000_0000}, 33);

        // hold start in END, result must not move
        held = bus.result_o;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            @(negedge clk);
            check_vec("hold_ready", 64'(bus.ready_o), 64'd1);
            check_vec("hold_result", bus.result_o, {32'h0000_0000, 32'h8000_0000});
        end
        bus.start_i = 1'b0;
        @(posedge clk);
        check_vec("hold_captured", held, {32'h0000_0000, 32'h8000_0000});
        do_div("b2b_9_3", 1'b0, 32'd9, 32'd3, {32'h0000_0000, 32'h0000_0003}, 33);
        release_start("b2b_9_3");

        // reset 10 cycles into ON
        @(negedge clk);
        bus.signed_div_i = 1'b0;
        bus.opdata1_i    = 32'd1000;
        bus.opdata2_i    = 32'd3;
        bus.start_i      = 1'b1;
        repeat (10) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        bus.start_i = 1'b0;
        check_vec("rst_abort_ready", 64'(bus.ready_o), 64'd0);
        check_vec("rst_abort_result", bus.result_o, 64'd0);
        seen = 1'b0;
        repeat (40) begin
            @(posedge clk);
            @(negedge clk);
            if (bus.ready_o || bus.result_o != 64'd0) seen = 1'b1;
        end
        check_vec("rst_abort_quiet", 64'(seen), 64'd0);

        // annul at cycle 15 of ON
        @(negedge clk);
        bus.signed_div_i = 1'b0;
        bus.opdata1_i    = 32'd100;
        bus.opdata2_i    = 32'd7;
        bus.start_i      = 1'b1;
        cyc  = 0;
        seen = 1'b0;
        while (cyc < 60 && !seen) begin
            @(posedge clk);
            @(negedge clk);
            cyc++;
            if (bus.ready_o) seen = 1'b1;
            if (cyc == 15) bus.annul_i = 1'b1;
            if (cyc == 16) begin
                bus.annul_i = 1'b0;
`ifdef DIV_UNIT_ANNUL_EN
                bus.start_i = 1'b0;
`endif
            end
        end
`ifdef DIV_UNIT_ANNUL_EN
        check_vec("annul_no_ready", 64'(seen), 64'd0);
        check_vec("annul_result", bus.result_o, 64'd0);
`else
        check_vec("annul_ignored_latency", 64'(cyc), 64'd33);
        check_vec("annul_ignored_result", bus.result_o, {32'h0000_0002, 32'h0000_000E});
        release_start("annul_ignored");
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/div_unit.md
DIV_UNIT -- requirements
Module: div_unit

Interface
REQ-001 SHALL have port clk, input, 1 bit: rising-edge clock; all state updates occur on this edge.
REQ-002 SHALL have port rst, input, 1 bit: reset, synchronous, active-high.
REQ-003 SHALL have port start_i, input, 1 bit: divide request from the EX stage, held high until the result is consumed.
REQ-004 SHALL have port signed_div_i, input, 1 bit: 1 for DIV (signed), 0 for DIVU (unsigned).
REQ-005 SHALL have port opdata1_i, input, 32 bits: dividend.
REQ-006 SHALL have port opdata2_i, input, 32 bits: divisor.
REQ-007 SHALL have port annul_i, input, 1 bit: pipeline flush or exception cancel.
REQ-008 SHALL have port result_o, output, 64 bits: {remainder[63:32] -> HI, quotient[31:0] -> LO}.
REQ-009 SHALL have port ready_o, output, 1 bit: result_o valid.

Function
REQ-010 SHALL implement a four-state FSM: IDLE, BYZERO, ON, END.
REQ-011 SHALL sample signed_div_i, opdata1_i and opdata2_i only in IDLE on the edge where start_i=1; later operand changes SHALL be ignored.
REQ-012 In IDLE with start_i=1, SHALL go to BYZERO if opdata2_i=0, else to ON with the iteration counter cleared to 0.
REQ-013 In BYZERO, SHALL go to END with result_o=0.
REQ-014 In ON, SHALL perform one restoring shift-subtract iteration per cycle over 32 cycles (counter 0..31), then go to END.
REQ-015 In signed mode, SHALL divide operand magnitudes (two's-complement negation of negative operands).
REQ-016 In signed mode, SHALL negate the quotient when the operand signs differ, and give the remainder the sign of the dividend.
REQ-017 Overflow case 0x80000000 / 0xFFFFFFFF signed SHALL yield quotient 0x80000000 and remainder 0, with no exception.
REQ-018 In END, SHALL hold ready_o=1 and result_o stable while start_i=1.
REQ-019 In END, SHALL return to IDLE on the first edge where start_i=0, clearing ready_o and result_o to 0.
REQ-020 Latency SHALL be: start sampled in cycle 0; nonzero divisor gives ready_o=1 in cycle 33; zero divisor gives ready_o=1 in cycle 2.
REQ-021 start_i=0 observed in ON or BYZERO SHALL abort to IDLE with ready_o=0 and result_o=0.
REQ-022 ready_o and result_o SHALL be registered outputs with no combinational path from any input.
REQ-023 Back-to-back requests SHALL be possible: start_i high again in the cycle after IDLE is re-entered begins a new division.

Reset
REQ-024 With rst=1 at an edge, SHALL set state=IDLE, counter=0, ready_o=0, result_o=0 and the internal dividend/divisor registers to 0.
REQ-025 rst SHALL override every other input, including mid-division; no partial result SHALL be visible afterwards.

Configuration
REQ-026 SHALL support the macro DIV_UNIT_ANNUL_EN.
REQ-027 When DIV_UNIT_ANNUL_EN is defined, annul_i=1 in any state SHALL force IDLE on the next edge with ready_o=0 and result_o=0, taking priority over start_i.
REQ-028 When DIV_UNIT_ANNUL_EN is undefined, annul_i SHALL remain a port but be ignored; only rst and start_i=0 abort a division.

Verification
REQ-029 Unsigned divide: DIVU 100/7, start held -> ready_o=1 at cycle 33, result_o={0x00000002,0x0000000E}.
REQ-030 Signed divide: DIV 0xFFFFFFF9 (-7) / 2 -> result_o={0xFFFFFFFF,0xFFFFFFFD}; the same operands as DIVU -> {0x00000001,0x7FFFFFFC}.
REQ-031 Divide by zero: DIV 5/0 -> ready_o=1 at cycle 2, result_o=0; then start_i=0 -> IDLE with ready_o=0.
REQ-032 Signed overflow: DIV 0x80000000 / 0xFFFFFFFF -> result_o={0x00000000,0x80000000}.
REQ-033 Abort: rst=1 at cycle 10 of ON -> outputs 0, state IDLE; with DIV_UNIT_ANNUL_EN, annul_i=1 at cycle 15 -> IDLE and no ready_o pulse; without the macro, the same annul_i -> ready_o at cycle 33.
REQ-034 Hold and back-to-back: keep start_i=1 five cycles in END -> result_o stable; drop start_i for one cycle, then raise it with new operands 9/3 -> {0,3} after 33 more cycles.
